// File: rtl/section_value_gen.sv
// Per-lane initial values for consecutive raster sections: lanes are filled
// serially by a running subtract, later sections subtract res*LANES per lane.

module section_lane #(
  parameter int VW = 18
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          wr,
  input  logic [VW-1:0] wr_val,
  input  logic          adv,
  input  logic [VW-1:0] step,
  output logic [VW-1:0] val
);
  always_ff @(posedge clk) begin
    if (n_rst)    val <= '0;
    else if (wr)  val <= wr_val;
    else if (adv) val <= val - step;
  end
endmodule

module section_value_gen #(
  parameter int LANES = 30,
  parameter int VW    = 18,
  parameter int RW    = 9,
  parameter int SW    = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [VW-1:0]       corner_b,
  input  logic [RW-1:0]       res,
  input  logic [SW-1:0]       num_sect,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SW-1:0]       out_sect,
  output logic                out_last,
  output logic [LANES*VW-1:0] load_val
);
  localparam int KW = (LANES > 2) ? $clog2(LANES) : 1;
  localparam int PW = (RW + 32 > VW) ? RW + 32 : VW;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  logic [1:0]                 state;
  logic [VW-1:0]              acc, step;
  logic [KW-1:0]              k;
  logic [RW-1:0]              res_q;
  logic [SW-1:0]              num_q;
  logic [PW-1:0]              prod;
  logic                       adv;
  logic [LANES-1:0][VW-1:0]   lanes;

  // full-width product, truncated only when stored
  assign prod     = PW'(res) * PW'(LANES);
  assign adv      = (state == PRESENT) && out_valid && out_ready && !out_last;
  assign busy     = (state != IDLE);
  assign load_val = lanes;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    section_lane #(.VW(VW)) u_lane (
      .clk    (clk),
      .n_rst  (n_rst),
      .wr     ((state == FILL) && (k == KW'(i))),
      .wr_val (acc),
      .adv    (adv),
      .step   (step),
      .val    (lanes[i])
    );
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state     <= IDLE;
      acc       <= '0;
      step      <= '0;
      k         <= '0;
      res_q     <= '0;
      num_q     <= '0;
      out_valid <= 1'b0;
      out_sect  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (num_sect != '0)) begin
            res_q <= res;
            num_q <= num_sect;
            acc   <= corner_b;
            k     <= '0;
            step  <= prod[VW-1:0];
            state <= FILL;
          end
        end
        FILL: begin
          acc <= acc - VW'(res_q);
          k   <= k + 1'b1;
          if (k == KW'(LANES - 1)) begin
            state     <= PRESENT;
            out_valid <= 1'b1;
            out_sect  <= '0;
            out_last  <= (num_q == SW'(1));
          end
        end
        PRESENT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_sect <= out_sect + 1'b1;
              out_last <= (SW'(out_sect + 1'b1) == SW'(num_q - 1'b1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
